dense_param_bn_act: RTL and testbench

Parametrised fully-connected layer: int8 MAC over `IN_DIM` inputs for each of `OUT_DIM` neurons, then requantise, batch-norm, and a run-time-selectable activation. Results land in an internal `OUT_W`-bit output buffer. It is the generic successor to the fixed 2048→128 dense stage and sits between a flatten/maxpool producer and the next dense or classifier stage. Weights and inputs come through external 1-cycle-latency read ports. Bias, scale and shift come through a config write port rather than being hard-wired.

---
 rtl/dense_pkg.sv | 35 +++
 rtl/dense_post_quant.sv | 67 ++++++
 rtl/dense_param_bn_act.sv | 177 +++++++++++++++++
 tb/tb_dense_param_bn_act.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and helpers for the parametrised dense + BN + activation stage.
// The optional BN stage is controlled by the DENSE_BN_EN macro in the other files.
package dense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_POST,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CFG_BIAS  = 2'd0,
        CFG_SCALE = 2'd1,
        CFG_SHIFT = 2'd2,
        CFG_NONE  = 2'd3
    } cfg_sel_t;

    localparam int RELU6_DIV = 42;
    localparam int RELU6_CAP = 6;

    // Wide enough for any accumulator the layer is built with.
    localparam int CLAMP_W = 64;

    function automatic logic signed [7:0] clamp_s8(input logic signed [CLAMP_W-1:0] v);
        if (v > 127)
            return 8'sd127;
        else if (v < -128)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/dense_post_quant.sv
// Combinational requantise -> batch-norm -> activation code for one neuron.
// With DENSE_BN_EN undefined the BN step is bypassed (b = a) and scale/shift ports vanish.
module dense_post_quant
    import dense_pkg::*;
#(
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 4,
    parameter int ACC_SHIFT = 5,
    parameter int BN_SHIFT  = 7
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    act_mode,
`ifdef DENSE_BN_EN
    input  logic signed [7:0]       scale,
    input  logic signed [7:0]       shift,
`endif
    output logic [OUT_W-1:0]        code,
    output logic                    sat
);

    function automatic logic [OUT_W-1:0] relu6_code(input logic [7:0] u);
        logic [7:0] q;
        q = u / 8'(RELU6_DIV);
        if (q > 8'(RELU6_CAP))
            q = 8'(RELU6_CAP);
        return q[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] lin_code(input logic [7:0] u);
        logic [7:0] q;
        q = u >> (8 - OUT_W);
        return q[OUT_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] acc_sh;
    logic signed [7:0]       a;
    logic signed [7:0]       b;
    logic                    sat_a;
    logic                    sat_b;
    logic [7:0]              u;
`ifdef DENSE_BN_EN
    logic signed [15:0]      bn_prod;
    logic signed [16:0]      bn_sum;
    logic signed [16:0]      bn_sh;
`endif

    always_comb begin
        acc_sh = acc >>> ACC_SHIFT;
        a      = clamp_s8({{(CLAMP_W-ACC_W){acc_sh[ACC_W-1]}}, acc_sh});
        sat_a  = ({{(ACC_W-8){a[7]}}, a} != acc_sh);
`ifdef DENSE_BN_EN
        bn_prod = 16'(a) * 16'(scale);
        bn_sum  = {bn_prod[15], bn_prod} + {{9{shift[7]}}, shift};
        bn_sh   = bn_sum >>> BN_SHIFT;
        b       = clamp_s8({{(CLAMP_W-17){bn_sh[16]}}, bn_sh});
        sat_b   = ({{9{b[7]}}, b} != bn_sh);
`else
        b       = a;
        sat_b   = 1'b0;
`endif
        // b + 128 for an int8 is just the sign bit flipped.
        u    = {~b[7], b[6:0]};
        code = act_mode ? lin_code(u) : relu6_code(u);
        sat  = sat_a | sat_b;
    end

endmodule

// File: rtl/dense_param_bn_act.sv
// Parametrised dense layer: int8 MAC per neuron, then requantise/BN/activation into out_buf.
// Batch-norm stage (scale/shift config arrays) is built only when DENSE_BN_EN is defined.
module dense_param_bn_act
    import dense_pkg::*;
#(
    parameter int IN_DIM    = 2048,
    parameter int OUT_DIM   = 128,
    parameter int OUT_W     = 4,
    parameter int ACC_W     = 32,
    parameter int ACC_SHIFT = 5,
    parameter int BN_SHIFT  = 7,
    localparam int IAW = $clog2(IN_DIM),
    localparam int WAW = $clog2(IN_DIM * OUT_DIM),
    localparam int OAW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              act_mode,
    output logic              busy,
    output logic              done,
    output logic              sat_flag,
    output logic [IAW-1:0]    in_addr,
    input  logic signed [7:0] in_data,
    output logic [WAW-1:0]    w_addr,
    input  logic signed [7:0] w_data,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [OAW-1:0]    cfg_addr,
    input  logic signed [7:0] cfg_data,
    input  logic [OAW-1:0]    rd_addr,
    output logic [OUT_W-1:0]  rd_data
);

    localparam int CW = $clog2(IN_DIM + 1);

    state_t                  state;
    state_t                  state_nx;
    logic [CW-1:0]           cnt;
    logic                    cnt_last;
    logic [OAW-1:0]          neu;
    logic                    neu_last;
    logic [WAW-1:0]          w_base;
    logic                    mode_r;
    logic [IAW-1:0]          prev_idx;

    logic signed [7:0]       in_buf [IN_DIM];
    logic signed [7:0]       bias_r [OUT_DIM];
`ifdef DENSE_BN_EN
    localparam logic signed [7:0] SCALE_RST = ((1 << BN_SHIFT) > 127) ? 8'sd127 : 8'(1 << BN_SHIFT);
    logic signed [7:0]       scale_r [OUT_DIM];
    logic signed [7:0]       shift_r [OUT_DIM];
`endif
    logic [OUT_W-1:0]        out_buf [OUT_DIM];

    logic signed [15:0]      mac_prod_p0;
    logic signed [ACC_W-1:0] acc_p1;
    logic [OUT_W-1:0]        pq_code;
    logic                    pq_sat;

    assign cnt_last = (cnt == CW'(IN_DIM));
    assign neu_last = (neu == OAW'(OUT_DIM - 1));
    assign prev_idx = IAW'(cnt - 1'b1);
    assign in_addr  = (state == ST_LOAD && !cnt_last) ? cnt[IAW-1:0] : '0;
    assign w_addr   = (state == ST_MAC && !cnt_last) ? w_base + WAW'(cnt) : '0;
    assign rd_data  = out_buf[rd_addr];

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_LOAD;
            ST_LOAD: begin
                busy = 1'b1;
                if (cnt_last) state_nx = ST_MAC;
            end
            ST_MAC: begin
                busy = 1'b1;
                if (cnt_last) state_nx = ST_POST;
            end
            ST_POST: begin
                busy     = 1'b1;
                state_nx = neu_last ? ST_DONE : ST_MAC;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            neu      <= '0;
            w_base   <= '0;
            mode_r   <= 1'b0;
            sat_flag <= 1'b0;
            for (int i = 0; i < OUT_DIM; i++) begin
                out_buf[i] <= '0;
                bias_r[i]  <= '0;
`ifdef DENSE_BN_EN
                scale_r[i] <= SCALE_RST;
                shift_r[i] <= '0;
`endif
            end
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        neu      <= '0;
                        w_base   <= '0;
                        mode_r   <= act_mode;
                        sat_flag <= 1'b0;
                    end
                end
                ST_LOAD, ST_MAC: cnt <= cnt_last ? '0 : cnt + 1'b1;
                ST_POST: begin
                    cnt          <= '0;
                    neu          <= neu_last ? '0 : neu + 1'b1;
                    w_base       <= w_base + WAW'(IN_DIM);
                    out_buf[neu] <= pq_code;
                    if (pq_sat) sat_flag <= 1'b1;
                end
                default: ;
            endcase
            // Config writes are accepted in every state.
            if (cfg_we && int'(cfg_addr) < OUT_DIM) begin
                case (cfg_sel_t'(cfg_sel))
                    CFG_BIAS:  bias_r[cfg_addr]  <= cfg_data;
`ifdef DENSE_BN_EN
                    CFG_SCALE: scale_r[cfg_addr] <= cfg_data;
                    CFG_SHIFT: shift_r[cfg_addr] <= cfg_data;
`endif
                    default: ;
                endcase
            end
        end
    end

    // p0: product of buffered input and weight returned for the previous address
    assign mac_prod_p0 = 16'(in_buf[prev_idx]) * 16'(w_data);

    // p1: input capture and accumulation (data only, no reset)
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && cnt != '0)
            in_buf[prev_idx] <= in_data;
        if (state == ST_MAC) begin
            if (cnt == '0)
                acc_p1 <= {{(ACC_W-8){bias_r[neu][7]}}, bias_r[neu]};
            else
                acc_p1 <= acc_p1 + {{(ACC_W-16){mac_prod_p0[15]}}, mac_prod_p0};
        end
    end

    dense_post_quant #(
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .ACC_SHIFT(ACC_SHIFT),
        .BN_SHIFT (BN_SHIFT)
    ) u_post (
        .acc     (acc_p1),
        .act_mode(mode_r),
`ifdef DENSE_BN_EN
        .scale   (scale_r[neu]),
        .shift   (shift_r[neu]),
`endif
        .code    (pq_code),
        .sat     (pq_sat)
    );

endmodule

// File: tb/tb_dense_param_bn_act.sv
// Directed bench for dense_param_bn_act at IN_DIM=4, OUT_DIM=2, OUT_W=4.
// Expected codes are hand-computed; BN-dependent values follow DENSE_BN_EN.
module tb_dense_param_bn_act;

    localparam int IN_DIM  = 4;
    localparam int OUT_DIM = 2;
    localparam int OUT_W   = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic              act_mode;
    logic              busy;
    logic              done;
    logic              sat_flag;
    logic [1:0]        in_addr;
    logic signed [7:0] in_data;
    logic [2:0]        w_addr;
    logic signed [7:0] w_data;
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [0:0]        cfg_addr;
    logic signed [7:0] cfg_data;
    logic [0:0]        rd_addr;
    logic [OUT_W-1:0]  rd_data;

    logic signed [7:0] in_mem [IN_DIM];
    logic signed [7:0] w_mem  [IN_DIM*OUT_DIM];

    int tests = 0;
    int fails = 0;
    int dcyc;
    int ndone;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
    end

    dense_param_bn_act #(
        .IN_DIM   (IN_DIM),
        .OUT_DIM  (OUT_DIM),
        .OUT_W    (OUT_W),
        .ACC_W    (32),
        .ACC_SHIFT(5),
        .BN_SHIFT (7)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .act_mode(act_mode),
        .busy    (busy),
        .done    (done),
        .sat_flag(sat_flag),
        .in_addr (in_addr),
        .in_data (in_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .cfg_we  (cfg_we),
        .cfg_sel (cfg_sel),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [0:0] addr, input logic signed [7:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic fill(input logic signed [7:0] iv, input logic signed [7:0] w0, input logic signed [7:0] w1);
        for (int i = 0; i < IN_DIM; i++) begin
            in_mem[i]          = iv;
            w_mem[i]           = w0;
            w_mem[IN_DIM + i]  = w1;
        end
    endtask

    task automatic read_check(input string tag, input logic [0:0] addr, input int exp);
        @(negedge clk);
        rd_addr = addr;
        #1;
        check(tag, 32'(rd_data), exp);
    endtask

    // Runs one layer pass; optional extra start pulse at cycle pulse_cyc.
    task automatic run(input logic mode, input int pulse_cyc, output int done_cyc);
        int n;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1; act_mode = mode;
        n = 0;
        while (n < 200 && done_cyc < 0) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                start = 1'b0; act_mode = ~mode;
                check("busy_cycle1", 32'(busy), 1);
            end
            if (n == pulse_cyc) start = 1'b1;
            else if (n == pulse_cyc + 1) start = 1'b0;
            if (n == 3)  check("in_addr_cycle3", 32'(in_addr), 2);
            if (n == 13) check("w_addr_cycle13", 32'(w_addr), 5);
            if (done) begin
                done_cyc = n;
                check("busy_in_done", 32'(busy), 0);
            end
        end
        check("done_cycle", done_cyc, 18);
        @(posedge clk);
        #1;
        check("done_one_pulse", 32'(done), 0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; act_mode = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0; rd_addr = '0;
        fill(8'sd0, 8'sd0, 8'sd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sat", 32'(sat_flag), 0);
        check("rst_in_addr", 32'(in_addr), 0);
        check("rst_w_addr", 32'(w_addr), 0);
        @(negedge clk);
        resetn = 1'b1;
        read_check("rst_rd0", 1'b0, 0);
        read_check("rst_rd1", 1'b1, 0);

        // Nominal ReLU6: a=4, b=2 (or 4 without BN) -> code 3
        fill(8'sd1, 8'sd32, 8'sd32);
        cfg(2'd1, 1'b0, 8'sd64);
        cfg(2'd1, 1'b1, 8'sd64);
        run(1'b0, -1, dcyc);
        read_check("nom_relu_rd0", 1'b0, 3);
        read_check("nom_relu_rd1", 1'b1, 3);
        check("nom_relu_sat", 32'(sat_flag), 0);

        // Linear mode: 130>>4 (or 132>>4) = 8
        run(1'b1, -1, dcyc);
        read_check("nom_lin_rd0", 1'b0, 8);
        read_check("nom_lin_rd1", 1'b1, 8);

        // Positive saturation
        fill(8'sd127, 8'sd127, 8'sd127);
        cfg(2'd1, 1'b0, 8'sd127);
        cfg(2'd1, 1'b1, 8'sd127);
        run(1'b0, -1, dcyc);
        read_check("pos_sat_rd0", 1'b0, 6);
        read_check("pos_sat_rd1", 1'b1, 6);
        check("pos_sat_flag", 32'(sat_flag), 1);

        // Negative saturation
        fill(8'sd127, -8'sd128, -8'sd128);
        run(1'b0, -1, dcyc);
        read_check("neg_sat_rd0", 1'b0, 0);
        read_check("neg_sat_rd1", 1'b1, 0);
        check("neg_sat_flag", 32'(sat_flag), 1);

        // Stray start during run is ignored; sat clears on the accepted start
        fill(8'sd1, 8'sd32, 8'sd32);
        cfg(2'd1, 1'b0, 8'sd64);
        cfg(2'd1, 1'b1, 8'sd64);
        run(1'b0, 5, dcyc);
        read_check("pulse_rd0", 1'b0, 3);
        read_check("pulse_rd1", 1'b1, 3);
        check("pulse_sat_cleared", 32'(sat_flag), 0);

        // Reset in cycle 9 of a run
        @(negedge clk);
        start = 1'b1; act_mode = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) ndone++;
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_busy_after", 32'(busy), 0);
        read_check("midrst_rd0", 1'b0, 0);
        read_check("midrst_rd1", 1'b1, 0);

        // Bias, scale/shift and ignored cfg_sel=3: n0 a=100, n1 a=-4
        fill(8'sd25, 8'sd32, 8'sd0);
        cfg(2'd0, 1'b1, -8'sd128);
        cfg(2'd1, 1'b0, 8'sd64);
        cfg(2'd1, 1'b1, 8'sd64);
        cfg(2'd2, 1'b1, -8'sd128);
        cfg(2'd3, 1'b1, 8'sd100);
        run(1'b0, -1, dcyc);
`ifdef DENSE_BN_EN
        read_check("cfg_relu_rd0", 1'b0, 4);
        read_check("cfg_relu_rd1", 1'b1, 2);
`else
        read_check("cfg_relu_rd0", 1'b0, 5);
        read_check("cfg_relu_rd1", 1'b1, 2);
`endif
        check("cfg_relu_sat", 32'(sat_flag), 0);
        run(1'b1, -1, dcyc);
`ifdef DENSE_BN_EN
        read_check("cfg_lin_rd0", 1'b0, 11);
        read_check("cfg_lin_rd1", 1'b1, 7);
`else
        read_check("cfg_lin_rd0", 1'b0, 14);
        read_check("cfg_lin_rd1", 1'b1, 7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
